// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: two-master round-robin arbiter with ACK watchdog for the shared register bus
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   m0_stb/we/adr/wdata        master 0 request, held until m0_ack or m0_err
//   m0_rdata/ack/err           master 0 read data, done pulse, timeout-abort pulse
//   m1_*                       identical set for master 1
//   stb/we/adr/wdata           slave request (latched from the granted master)
//   rdata/ack                  slave read data and acknowledge
//   gnt                        one-hot current grant (bit0 = M0, bit1 = M1), 0 when idle
module bus_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              stb,
  output logic              we,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack,
  output logic [1:0]        gnt
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic last;
  logic pick;
  logic done;
  // M1 wins when it is the only requester, or on a tie when M0 was served last
  always_comb pick = m1_stb & (~m0_stb | ~last);
  always_comb done = ack | (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      stb      <= 1'b0;
      we       <= 1'b0;
      adr      <= '0;
      wdata    <= '0;
      gnt      <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: if (m0_stb | m1_stb) begin
          we    <= pick ? m1_we : m0_we;
          adr   <= pick ? m1_adr : m0_adr;
          wdata <= pick ? m1_wdata : m0_wdata;
          gnt   <= pick ? 2'b10 : 2'b01;
          stb   <= 1'b1;
          cnt   <= '0;
          state <= BUS;
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // ACK takes priority over a watchdog expiry on the same cycle
          if (ack) begin
            if (gnt[1]) m1_rdata <= rdata;
            else m0_rdata <= rdata;
            m1_ack <= gnt[1];
            m0_ack <= gnt[0];
          end else if (done) begin
            m1_err <= gnt[1];
            m0_err <= gnt[0];
          end
          if (done) begin
            stb   <= 1'b0;
            gnt   <= '0;
            last  <= gnt[1];
            state <= RELEASE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed table-driven and sequence checks for bus_rr_arbiter
module tb_bus_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0, ack = 1'b0;
  logic [31:0] m0_adr = '0, m0_wdata = '0, m1_adr = '0, m1_wdata = '0, rdata = '0;
  logic [31:0] m0_rdata, m1_rdata, adr, wdata;
  logic m0_ack, m0_err, m1_ack, m1_err, stb, we;
  logic [1:0] gnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bus_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .stb(stb), .we(we), .adr(adr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .gnt(gnt)
  );
  typedef struct {
    logic s0, s1, ak;
    logic [31:0] rd;
    logic stb;
    logic [1:0] gnt;
    logic a0, a1, e0, e1, we;
    logic [31:0] adr, x0, x1;
  } vec_t;
  vec_t tbl[12];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m0_stb = 1'b0; m1_stb = 1'b0; ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    logic [1:0] exp_gnt;
    logic [31:0] keep;
    int n;
    m0_adr = 32'h0200_0100; m0_we = 1'b0; m0_wdata = 32'h1111_2222;
    m1_adr = 32'h0200_0200; m1_we = 1'b1; m1_wdata = 32'h0000_CAFE;
    //               s0  s1  ak  rd            stb  gnt    a0  a1  e0  e1  we  adr            x0            x1
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0,        32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0,        32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b1,32'h1234_5678,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h1234_5678,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h1234_5678,32'h0};
    tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0200_0200,32'h1234_5678,32'h0};
    tbl[5]  = '{1'b1,1'b1,1'b1,32'hAAAA_5555,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0200_0200,32'h1234_5678,32'hAAAA_5555};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0200_0200,32'h1234_5678,32'hAAAA_5555};
    tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h1234_5678,32'hAAAA_5555};
    tbl[8]  = '{1'b1,1'b0,1'b1,32'h0BAD_F00D,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0BAD_F00D,32'hAAAA_5555};
    tbl[9]  = '{1'b0,1'b0,1'b1,32'h5A5A_5A5A,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0BAD_F00D,32'hAAAA_5555};
    tbl[10] = '{1'b0,1'b0,1'b1,32'h5A5A_5A5A,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0BAD_F00D,32'hAAAA_5555};
    tbl[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0200_0100,32'h0BAD_F00D,32'hAAAA_5555};
    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      m0_stb = 1'($urandom); m1_stb = 1'($urandom); ack = 1'($urandom);
      rdata = $urandom;
      tick();
      chk("reset_outputs", {stb, we, gnt, m0_ack, m1_ack, m0_err, m1_err, adr, wdata, m0_rdata, m1_rdata},
          128'h0);
    end
    m0_stb = 1'b0; m1_stb = 1'b0; ack = 1'b0; rdata = '0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {stb, gnt}, 128'h0);
    // cycle-by-cycle vector table
    for (int i = 0; i < 12; i++) begin
      m0_stb = tbl[i].s0; m1_stb = tbl[i].s1; ack = tbl[i].ak; rdata = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d", i),
          {stb, gnt, m0_ack, m1_ack, m0_err, m1_err, we, adr, m0_rdata, m1_rdata},
          {tbl[i].stb, tbl[i].gnt, tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1, tbl[i].we,
           tbl[i].adr, tbl[i].x0, tbl[i].x1});
    end
    ack = 1'b0;
    // continuous contention from a fresh reset alternates M0,M1,M0,M1
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (!stb && n < 5) begin
        tick();
        n++;
      end
      chk($sformatf("rr_stb%0d", t), {31'h0, stb}, 128'h1);
      chk($sformatf("rr_gnt%0d", t), {126'h0, gnt}, {126'h0, exp_gnt});
      ack = 1'b1; rdata = 32'h100 + t;
      tick();
      ack = 1'b0;
      chk($sformatf("rr_ack%0d", t), {m1_ack, m0_ack}, {126'h0, exp_gnt});
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick();
    tick();
    // watchdog: M1 write to an address nobody acks
    keep = 32'h103;
    m1_stb = 1'b1;
    tick();
    n = 0;
    while (stb && n < 40) begin
      chk("to_no_early_err", {m1_err, m1_ack}, 128'h0);
      n++;
      tick();
    end
    chk("to_stb_cycles", n, 16);
    chk("to_err_pulse", {m1_err, m1_ack, m0_err, m0_ack}, 128'h8);
    chk("to_rdata_kept", m1_rdata, keep);
    m1_stb = 1'b0;
    tick();
    chk("to_err_cleared", {m1_err, m1_ack}, 128'h0);
    tick();
    // ACK on the final watchdog cycle wins
    m0_stb = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("co_stb_still_high", {stb, gnt}, 128'h5);
    ack = 1'b1; rdata = 32'hFEED_0016;
    tick();
    ack = 1'b0; m0_stb = 1'b0;
    chk("co_ack_not_err", {m0_ack, m0_err, m0_rdata}, {2'b10, 32'hFEED_0016});
    tick();
    tick();
    // asynchronous reset in the middle of a transfer
    m0_stb = 1'b1;
    tick();
    chk("ar_in_bus", {stb, gnt}, 128'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async_drop", {stb, gnt, m0_ack, m0_err}, 128'h0);
    m1_stb = 1'b1;
    tick();
    chk("ar_no_ack_err", {m0_ack, m0_err, m1_ack, m1_err}, 128'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_tie_m0_first", {stb, gnt}, 128'h5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
